// File: rtl/data_bus_shim.sv
// Core-to-memory data bus shim: one request in flight, programmable grant/response delays, address window check, response timeout.
// Latency: gnt GNT_DELAY cycles after req is sampled, rvalid 3+RSP_DELAY cycles after gnt; no backpressure, core holds req until gnt.
module data_bus_shim #(
  parameter int unsigned GNT_DELAY = 2,
  parameter int unsigned RSP_DELAY = 1,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] req_count_o
);

  localparam logic [3:0]  GNT_CNT  = 4'(GNT_DELAY);
  localparam logic [3:0]  RSP_CNT  = 4'(RSP_DELAY);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [32:0] WIN_LO   = {1'b0, ADDR_BASE};
  localparam logic [32:0] WIN_HI   = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE};

  typedef enum logic [2:0] {IDLE, STALL, ISSUE, WAIT_RSP, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  tmo_cnt;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        addr_legal;

  // 33-bit compare so a word straddling 2^32 is rejected rather than wrapping.
  assign addr_legal = ({1'b0, data_addr_i} >= WIN_LO) &&
                      (({1'b0, data_addr_i} + 33'd3) < WIN_HI);

  // Every output is a pulse register: cleared each cycle and set on the edge entering the cycle that owns it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      tmo_cnt       <= 8'd0;
      rdata_q       <= 32'd0;
      err_q         <= 1'b0;
      req_count_o   <= 32'd0;
      data_gnt_o    <= 1'b0;
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
      data_rdata_o  <= 32'd0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_be_o      <= 4'd0;
      mem_addr_o    <= 32'd0;
      mem_wdata_o   <= 32'd0;
    end else begin
      data_gnt_o    <= 1'b0;
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
      data_rdata_o  <= 32'd0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_be_o      <= 4'd0;
      mem_addr_o    <= 32'd0;
      mem_wdata_o   <= 32'd0;
      case (state)
        IDLE: begin
          if (data_req_i) begin
            state      <= STALL;
            cnt        <= GNT_CNT;
            data_gnt_o <= (GNT_CNT == 4'd0);
          end
        end
        STALL: begin
          if (cnt == 4'd0) begin
            req_count_o <= req_count_o + 32'd1;
            if (addr_legal) begin
              state       <= ISSUE;
              mem_req_o   <= 1'b1;
              mem_we_o    <= data_we_i;
              mem_be_o    <= data_be_i;
              mem_addr_o  <= data_addr_i;
              mem_wdata_o <= data_wdata_i;
            end else begin
              state   <= RESP;
              cnt     <= RSP_CNT;
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
              if (RSP_CNT == 4'd0) begin
                data_rvalid_o <= 1'b1;
                data_err_o    <= 1'b1;
              end
            end
          end else if (!data_req_i) begin
            state <= IDLE;
          end else begin
            cnt        <= cnt - 4'd1;
            data_gnt_o <= (cnt == 4'd1);
          end
        end
        ISSUE: begin
          state   <= WAIT_RSP;
          tmo_cnt <= 8'd0;
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            state   <= RESP;
            cnt     <= RSP_CNT;
            rdata_q <= mem_rdata_i;
            err_q   <= mem_err_i;
            if (RSP_CNT == 4'd0) begin
              data_rvalid_o <= 1'b1;
              data_rdata_o  <= mem_rdata_i;
              data_err_o    <= mem_err_i;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state         <= RESP;
            cnt           <= 4'd0;
            rdata_q       <= 32'd0;
            err_q         <= 1'b1;
            data_rvalid_o <= 1'b1;
            data_err_o    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          if (cnt == 4'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              data_rvalid_o <= 1'b1;
              data_rdata_o  <= rdata_q;
              data_err_o    <= err_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_shim.sv
// Bench for data_bus_shim: two configurations sharing stimulus, one held in reset while the other is exercised.
// Expected timing and data come from a transaction-level model of the request/response rules.
module tb_data_bus_shim;
  localparam int          GD_A = 2, RD_A = 1, TMO_A = 16;
  localparam logic [31:0] BASE_A = 32'h0000_0000, SIZE_A = 32'h0000_0100;
  localparam int          GD_B = 0, RD_B = 0, TMO_B = 3;
  localparam logic [31:0] BASE_B = 32'h0000_1000, SIZE_B = 32'h0000_0040;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic        req, we, m_rvalid, m_err;
  logic [3:0]  be;
  logic [31:0] addr, wdata, m_rdata;

  logic        gnt_a, rv_a, err_a, mreq_a, mwe_a;
  logic [3:0]  mbe_a;
  logic [31:0] rdata_a, maddr_a, mwdata_a, cnt_a;
  logic        gnt_b, rv_b, err_b, mreq_b, mwe_b;
  logic [3:0]  mbe_b;
  logic [31:0] rdata_b, maddr_b, mwdata_b, cnt_b;

  logic        o_gnt, o_rv, o_err, o_mreq, o_mwe, o_any;
  logic [3:0]  o_mbe;
  logic [31:0] o_rdata, o_maddr, o_mwdata, o_cnt;

  assign o_gnt    = sel ? gnt_b    : gnt_a;
  assign o_rv     = sel ? rv_b     : rv_a;
  assign o_err    = sel ? err_b    : err_a;
  assign o_rdata  = sel ? rdata_b  : rdata_a;
  assign o_mreq   = sel ? mreq_b   : mreq_a;
  assign o_mwe    = sel ? mwe_b    : mwe_a;
  assign o_mbe    = sel ? mbe_b    : mbe_a;
  assign o_maddr  = sel ? maddr_b  : maddr_a;
  assign o_mwdata = sel ? mwdata_b : mwdata_a;
  assign o_cnt    = sel ? cnt_b    : cnt_a;
  assign o_any    = o_gnt | o_rv | o_err | o_mreq | o_mwe | (|o_mbe) | (|o_rdata) |
                    (|o_maddr) | (|o_mwdata) | (|o_cnt);

  data_bus_shim #(.GNT_DELAY(GD_A), .RSP_DELAY(RD_A), .TIMEOUT(TMO_A),
                  .ADDR_BASE(BASE_A), .ADDR_SIZE(SIZE_A)) u_dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .data_req_i(req), .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt_a), .data_rvalid_o(rv_a), .data_err_o(err_a), .data_rdata_o(rdata_a),
    .mem_req_o(mreq_a), .mem_we_o(mwe_a), .mem_be_o(mbe_a), .mem_addr_o(maddr_a), .mem_wdata_o(mwdata_a),
    .mem_rvalid_i(m_rvalid), .mem_err_i(m_err), .mem_rdata_i(m_rdata), .req_count_o(cnt_a));

  data_bus_shim #(.GNT_DELAY(GD_B), .RSP_DELAY(RD_B), .TIMEOUT(TMO_B),
                  .ADDR_BASE(BASE_B), .ADDR_SIZE(SIZE_B)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .data_req_i(req), .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_gnt_o(gnt_b), .data_rvalid_o(rv_b), .data_err_o(err_b), .data_rdata_o(rdata_b),
    .mem_req_o(mreq_b), .mem_we_o(mwe_b), .mem_be_o(mbe_b), .mem_addr_o(maddr_b), .mem_wdata_o(mwdata_b),
    .mem_rvalid_i(m_rvalid), .mem_err_i(m_err), .mem_rdata_i(m_rdata), .req_count_o(cnt_b));

  int total = 0;
  int bad   = 0;
  int exp_cnt_a = 0;
  int exp_cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a, input logic [31:0] base, input logic [31:0] size);
    longint la, lb, ls;
    la = longint'(a);
    lb = longint'(base);
    ls = longint'(size);
    return (la >= lb) && (la + 3 < lb + ls);
  endfunction

  function automatic logic [31:0] pick_addr(input logic [31:0] base, input logic [31:0] size);
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5)      return base + (32'($urandom_range(0, size / 4 - 1)) << 2);
    else if (r == 6) return base + size - 32'd4;
    else if (r == 7) return base + size - 32'd3;
    else if (r == 8) return base - 32'd2;
    else             return $urandom;
  endfunction

  // One transaction on the selected instance; lat = cycles after mem_req at which memory answers (0 = never).
  task automatic txn(input logic t_we, input logic [3:0] t_be, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                     input int lat, input logic r_err, input logic [31:0] r_data, input bit spur, input string tag);
    int gd, rd, tmo, eg, eiss, erv, ecnt;
    bit legal, answered;
    int g_cyc, n_g, m_cyc, n_m, r_cyc, n_r, viol;
    logic        m_we_s, r_err_s;
    logic [3:0]  m_be_s;
    logic [31:0] m_addr_s, m_wdata_s, r_dat_s;
    gd    = sel ? GD_B : GD_A;
    rd    = sel ? RD_B : RD_A;
    tmo   = sel ? TMO_B : TMO_A;
    legal = sel ? in_window(t_addr, BASE_B, SIZE_B) : in_window(t_addr, BASE_A, SIZE_A);
    answered = legal && lat >= 1 && lat <= tmo;
    eg   = gd + 1;
    eiss = eg + 1;
    if (!legal)        erv = eg + 1 + rd;
    else if (answered) erv = eiss + lat + 1 + rd;
    else               erv = eiss + 1 + tmo;
    g_cyc = -1; m_cyc = -1; r_cyc = -1; n_g = 0; n_m = 0; n_r = 0; viol = 0;
    m_we_s = 1'b0; m_be_s = 4'd0; m_addr_s = 32'd0; m_wdata_s = 32'd0; r_dat_s = 32'd0; r_err_s = 1'b0;
    req = 1'b1; we = t_we; be = t_be; addr = t_addr; wdata = t_wdata;
    for (int c = 1; c <= erv + 2; c++) begin
      @(negedge clk);
      if (o_gnt) begin
        if (n_g == 0) g_cyc = c;
        n_g++;
      end
      if (o_mreq) begin
        n_m++; m_cyc = c;
        m_we_s = o_mwe; m_be_s = o_mbe; m_addr_s = o_maddr; m_wdata_s = o_mwdata;
      end else if (o_mwe || o_mbe != 4'd0 || o_maddr != 32'd0 || o_mwdata != 32'd0) viol++;
      if (o_rv) begin
        n_r++; r_cyc = c; r_dat_s = o_rdata; r_err_s = o_err;
        if (o_gnt) viol++;
      end else if (o_err || o_rdata != 32'd0) viol++;
      if (c == eg) req = 1'b0;
      if (c == eg + 1) begin
        we = 1'($urandom); be = 4'($urandom); addr = $urandom; wdata = $urandom;
      end
      m_rvalid = 1'b0; m_err = 1'($urandom); m_rdata = $urandom;
      if (legal && lat >= 1 && c == eiss + lat) begin
        m_rvalid = 1'b1; m_err = r_err; m_rdata = r_data;
      end else if (spur && (c == eiss || c == erv || c == erv + 1)) m_rvalid = 1'b1;
    end
    m_rvalid = 1'b0;
    if (sel) begin exp_cnt_b++; ecnt = exp_cnt_b; end
    else begin exp_cnt_a++; ecnt = exp_cnt_a; end
    check({tag, "/gnt_cycle"}, 32'(g_cyc), 32'(eg));
    check({tag, "/gnt_pulses"}, 32'(n_g), 32'd1);
    check({tag, "/mem_pulses"}, 32'(n_m), legal ? 32'd1 : 32'd0);
    if (legal) begin
      check({tag, "/mem_cycle"}, 32'(m_cyc), 32'(eiss));
      check({tag, "/mem_we"}, 32'(m_we_s), 32'(t_we));
      check({tag, "/mem_be"}, 32'(m_be_s), 32'(t_be));
      check({tag, "/mem_addr"}, m_addr_s, t_addr);
      check({tag, "/mem_wdata"}, m_wdata_s, t_wdata);
    end
    check({tag, "/rvalid_cycle"}, 32'(r_cyc), 32'(erv));
    check({tag, "/rvalid_pulses"}, 32'(n_r), 32'd1);
    check({tag, "/rdata"}, r_dat_s, answered ? r_data : 32'd0);
    check({tag, "/err"}, 32'(r_err_s), answered ? 32'(r_err) : 32'd1);
    check({tag, "/req_count"}, o_cnt, 32'(ecnt));
    check({tag, "/idle_outputs_zero"}, 32'(viol), 32'd0);
  endtask

  task automatic rand_txns(input int n, input string tag);
    int tmo, lat;
    logic [31:0] base, size;
    for (int i = 0; i < n; i++) begin
      tmo  = sel ? TMO_B : TMO_A;
      base = sel ? BASE_B : BASE_A;
      size = sel ? SIZE_B : SIZE_A;
      lat  = int'($urandom_range(0, 32'(tmo + 1)));
      txn(1'($urandom), 4'($urandom), pick_addr(base, size), $urandom, lat,
          1'($urandom), $urandom, 1'($urandom), tag);
    end
  endtask

  initial begin
    int n_ev, n_gr, last_rv, gap_bad, both;
    bit pend;
    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
    req = 1'b0; we = 1'b0; be = 4'd0; addr = 32'd0; wdata = 32'd0;
    m_rvalid = 1'b0; m_err = 1'b0; m_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset/a_outputs", 32'(o_any), 32'd0);
    sel = 1'b1;
    check("reset/b_outputs", 32'(o_any), 32'd0);
    sel = 1'b0;
    rst_a = 1'b0;
    @(negedge clk);

    txn(1'b0, 4'hF, 32'h10, 32'd0, 1, 1'b0, 32'hDEAD_BEEF, 1'b0, "read_0x10");
    txn(1'b1, 4'b0011, 32'h20, 32'h0000_ABCD, 1, 1'b0, 32'h1234_5678, 1'b0, "write_0x20");
    txn(1'b0, 4'hF, 32'hFE, 32'd0, 1, 1'b0, 32'h5555_AAAA, 1'b1, "read_0xFE_oob");
    txn(1'b0, 4'hF, 32'hFC, 32'd0, 2, 1'b1, 32'hCAFE_F00D, 1'b0, "read_last_word");

    // Core withdraws the request before it is granted.
    req = 1'b1; addr = 32'h10;
    @(negedge clk);
    req = 1'b0;
    n_ev = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_gnt || o_mreq || o_rv) n_ev++;
    end
    check("withdraw/no_events", 32'(n_ev), 32'd0);
    check("withdraw/req_count", o_cnt, 32'(exp_cnt_a));

    txn(1'b0, 4'hF, 32'h30, 32'd0, 0, 1'b0, 32'd0, 1'b1, "timeout");

    // Reset while waiting on memory, then a stale response arrives.
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h40;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) req = 1'b0;
    end
    rst_a = 1'b1;
    @(negedge clk);
    check("reset_in_wait/outputs", 32'(o_any), 32'd0);
    rst_a = 1'b0; exp_cnt_a = 0;
    m_rvalid = 1'b1; m_err = 1'b1; m_rdata = 32'hBAD0_BAD0;
    n_ev = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (o_gnt || o_mreq || o_rv) n_ev++;
      m_rvalid = (c < 1);
    end
    check("reset_in_wait/quiet", 32'(n_ev), 32'd0);
    check("reset_in_wait/req_count", o_cnt, 32'd0);
    txn(1'b0, 4'hF, 32'h44, 32'd0, 1, 1'b0, 32'h0BAD_F00D, 1'b0, "after_reset");

    rand_txns(24, "rand_a");

    rst_a = 1'b1; rst_b = 1'b0; sel = 1'b1;
    @(negedge clk);

    // Request held high continuously: each grant lands two cycles after the previous rvalid.
    req = 1'b1; we = 1'b0; be = 4'hF; addr = BASE_B;
    pend = 1'b0; n_gr = 0; last_rv = -1; gap_bad = 0; both = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (o_gnt) begin
        n_gr++;
        if (last_rv >= 0 && c - last_rv != 2) gap_bad++;
        if (last_rv < 0 && c != 1) gap_bad++;
      end
      if (o_rv) begin
        last_rv = c;
        if (o_gnt) both++;
      end
      m_rvalid = pend; m_err = 1'b0; m_rdata = 32'(c);
      pend = o_mreq;
      if (c == 60) req = 1'b0;
    end
    m_rvalid = 1'b0;
    exp_cnt_b = 12;
    check("held_req/grants", 32'(n_gr), 32'd12);
    check("held_req/gnt_spacing", 32'(gap_bad), 32'd0);
    check("held_req/gnt_in_rvalid", 32'(both), 32'd0);
    check("held_req/req_count", o_cnt, 32'(exp_cnt_b));
    @(negedge clk);

    txn(1'b0, 4'hF, BASE_B + 32'h3C, 32'd0, 3, 1'b0, 32'h7777_1111, 1'b0, "b_last_wait_cycle");
    txn(1'b0, 4'hF, BASE_B - 32'd4, 32'd0, 1, 1'b0, 32'h0, 1'b1, "b_below_base");
    rand_txns(16, "rand_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/data_bus_shim.md
DATA_BUS_SHIM -- requirements
Module: data_bus_shim

Interface
REQ-001 Parameter GNT_DELAY, default 2: cycles data_req_i is held before data_gnt_o asserts (range 0..15).
REQ-002 Parameter RSP_DELAY, default 1: extra cycles between memory response capture and data_rvalid_o (range 0..15).
REQ-003 Parameter TIMEOUT, default 16: max WAIT_RSP cycles before an error response (range 1..255).
REQ-004 Parameter ADDR_BASE, default 32'h0000_0000: lowest legal byte address.
REQ-005 Parameter ADDR_SIZE, default 32'h0000_0100: window size in bytes; legal iff ADDR_BASE <= addr and addr+3 < ADDR_BASE+ADDR_SIZE, compared in 33 bits.
REQ-006 clk_i  in  1  clock; all state updates on rising edge.
REQ-007 rst_i  in  1  reset, synchronous, active-high.
REQ-008 data_req_i, data_we_i  in  1 each  core request, write enable.
REQ-009 data_be_i  in  4  core byte enables; data_addr_i, data_wdata_i  in  32 each.
REQ-010 data_gnt_o, data_rvalid_o, data_err_o  out  1 each  core-side grant, response valid, response error.
REQ-011 data_rdata_o  out  32  core-side read data.
REQ-012 mem_req_o, mem_we_o  out  1 each; mem_be_o  out  4; mem_addr_o, mem_wdata_o  out  32 each  memory-side request.
REQ-013 mem_rvalid_i, mem_err_i  in  1 each; mem_rdata_i  in  32  memory-side response.
REQ-014 req_count_o  out  32  number of granted requests, wraps at 2^32.

Function
REQ-015 FSM states IDLE, STALL, ISSUE, WAIT_RSP, RESP; one request outstanding at a time.
REQ-016 IDLE: data_req_i=1 -> STALL, cnt<=GNT_DELAY; else stay.
REQ-017 STALL: data_gnt_o=1 exactly in the cycle cnt==0 (Moore output); that edge latches we/be/addr/wdata, increments req_count_o, goes to ISSUE if address legal, else RESP with err_q=1, rdata_q=0, cnt<=RSP_DELAY; cnt>0 -> cnt decrements.
REQ-018 data_req_i dropping in STALL before grant (protocol violation) -> return to IDLE, no grant, no count.
REQ-019 ISSUE: mem_req_o=1 for exactly one cycle with latched fields, then WAIT_RSP with timeout counter cleared.
REQ-020 mem_* request outputs SHALL be 0 in every state other than ISSUE.
REQ-021 WAIT_RSP: mem_rvalid_i=1 -> latch mem_rdata_i, mem_err_i, cnt<=RSP_DELAY, RESP; else timeout counter increments; reaching TIMEOUT -> err_q=1, rdata_q=0, RESP.
REQ-022 mem_rvalid_i in any state other than WAIT_RSP SHALL be ignored.
REQ-023 RESP: cnt==0 -> data_rvalid_o=1 for one cycle with data_rdata_o=rdata_q, data_err_o=err_q, then IDLE; else cnt decrements.
REQ-024 data_rdata_o and data_err_o SHALL be 0 whenever data_rvalid_o=0.
REQ-025 For writes, data_rdata_o on rvalid SHALL be the captured mem_rdata_i (passthrough, not masked).
REQ-026 Latency, legal request, memory answering one cycle after mem_req_o: req-to-gnt = GNT_DELAY cycles, gnt-to-rvalid = 3+RSP_DELAY cycles.
REQ-027 New data_req_i seen in RESP's rvalid cycle SHALL not be granted that cycle; IDLE samples it next cycle.

Reset
REQ-028 rst_i=1 at an edge -> state IDLE, all counters 0, latched fields 0, req_count_o=0; all outputs 0 the following cycle.
REQ-029 Reset overrides any in-flight request in any state; a later mem_rvalid_i for the aborted request is dropped (REQ-022).

Verification
REQ-030 GNT_DELAY=2, RSP_DELAY=1; read addr 0x10, memory returns 0xDEADBEEF next cycle -> gnt 2 cycles after req, rvalid 4 cycles after gnt, rdata 0xDEADBEEF, err 0, req_count_o=1.
REQ-031 Write addr 0x20, be=4'b0011, wdata 0x0000_ABCD -> single mem_req_o pulse with mem_we_o=1, mem_be_o=4'b0011, mem_addr_o=0x20, mem_wdata_o=0x0000_ABCD.
REQ-032 Read addr 0xFE (ADDR_SIZE 0x100) -> gnt, no mem_req_o, rvalid with err=1, rdata=0.
REQ-033 TIMEOUT=16, memory never responds -> rvalid with err=1 exactly 16 cycles after entering WAIT_RSP; late mem_rvalid_i afterwards ignored.
REQ-034 rst_i asserted in WAIT_RSP -> no rvalid, all outputs 0 next cycle, req_count_o=0; next request completes normally.
REQ-035 GNT_DELAY=0, back-to-back requests, data_req_i held high -> gnt asserted the cycle after each IDLE visit, no gnt in any rvalid cycle, req_count_o matches number of grants.
